// File: rtl/shift_rotate_seq.sv
// Sequential 8-bit arithmetic-shift / rotate unit: one bit position per clock,
// with a start/busy/done handshake. It shares its shift-amount encoding with the ALU's logical shifter.
module shift_rotate_seq (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic       op_i,
   input  logic [7:0] data_i,
   input  logic [7:0] amount_i,
   output logic [7:0] result_o,
   output logic       busy_o,
   output logic       done_o
);

   typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

   state_t      state_q;
   logic [7:0]  res_q, res_d;
   logic [2:0]  cnt_q;
   logic        dir_q;   // 1 = right
   logic        rot_q;   // 1 = rotate, 0 = arithmetic
   logic        busy_q, done_q;

   logic unused_amt;
   assign unused_amt = ^amount_i[6:3];

   always_comb begin
      res_d = res_q;
      case ({rot_q, dir_q})
         2'b00:   res_d = {res_q[6:0], 1'b0};
         2'b01:   res_d = {res_q[7], res_q[7:1]};
         2'b10:   res_d = {res_q[6:0], res_q[7]};
         default: res_d = {res_q[0], res_q[7:1]};
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         res_q   <= 8'h00;
         cnt_q   <= 3'd0;
         dir_q   <= 1'b0;
         rot_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  res_q  <= data_i;
                  cnt_q  <= amount_i[2:0];
                  dir_q  <= amount_i[7];
                  rot_q  <= op_i;
                  busy_q <= 1'b1;
                  if (amount_i[2:0] == 3'd0) begin
                     state_q <= FIN;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               res_q <= res_d;
               cnt_q <= cnt_q - 3'd1;
               // Last bit move this edge: present DONE during the following cycle.
               if (cnt_q == 3'd1) begin
                  state_q <= FIN;
                  done_q  <= 1'b1;
               end
            end
            FIN: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign result_o = res_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Scoreboard bench for shift_rotate_seq: the stimulus side queues the expected result and DONE cycle,
// and a negedge monitor checks each DONE pulse against them.
module tb_shift_rotate_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       op = 1'b0;
   logic [7:0] data = 8'h00;
   logic [7:0] amount = 8'h00;
   logic [7:0] result;
   logic       busy, done;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] res;
      int         cyc;
   } exp_t;

   exp_t sbq[$];

   shift_rotate_seq dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op),
      .data_i(data), .amount_i(amount),
      .result_o(result), .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] ref_model(input logic [7:0] d, input logic [7:0] a, input logic o);
      int n, l, v;
      n = int'(a[2:0]);
      v = int'(d);
      if (!o) begin
         if (a[7]) return 8'($signed(d) >>> n);
         return 8'((v << n) & 255);
      end
      l = a[7] ? (8 - n) % 8 : n;
      return 8'(((v << l) | (v >> (8 - l))) & 255);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every DONE pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: done=1 with no outstanding op (cycle %0d)", cyc);
            end else begin
               e = sbq.pop_front();
               chk("result_at_done", int'(result), int'(e.res));
               chk("done_cycle", cyc, e.cyc);
               chk("busy_at_done", int'(busy), 1);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      sbq.delete();
      @(posedge clk);
      #1;
      chk("reset_result", int'(result), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      reset = 1'b0;
   endtask

   task automatic wait_drain(input logic [7:0] res);
      int t = 0;
      while (sbq.size() != 0 && t < 30) begin
         @(negedge clk);
         #2;
         t++;
      end
      if (sbq.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL timeout: no done within 30 cycles, expected result 0x%0h", res);
         do_reset();
      end else begin
         @(negedge clk);
         chk("idle_busy", int'(busy), 0);
         chk("idle_result_hold", int'(result), int'(res));
      end
   endtask

   task automatic issue(input logic [7:0] d, input logic [7:0] a, input logic o);
      exp_t e;
      @(negedge clk);
      data = d; amount = a; op = o; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e.res = ref_model(d, a, o);
      e.cyc = cyc + int'(a[2:0]);
      sbq.push_back(e);
      chk("busy_after_accept", int'(busy), 1);
      // Scramble inputs after the accept edge; the operation must be latched.
      data = 8'($urandom); amount = 8'($urandom); op = 1'($urandom);
   endtask

   task automatic run_op(input logic [7:0] d, input logic [7:0] a, input logic o);
      issue(d, a, o);
      wait_drain(ref_model(d, a, o));
   endtask

   initial begin
      do_reset();

      run_op(8'h96, 8'h82, 1'b0);   // SRA 2 -> E5
      run_op(8'h96, 8'h03, 1'b1);   // ROL 3 -> B4
      run_op(8'h01, 8'h87, 1'b1);   // ROR 7 -> 02
      run_op(8'h70, 8'h84, 1'b0);   // -> 07
      run_op(8'hFF, 8'h04, 1'b0);   // -> F0
      run_op(8'h80, 8'h87, 1'b0);   // -> FF
      run_op(8'h5A, 8'hF8, 1'b1);   // count 0 -> 5A

      // START pulses while busy are ignored
      issue(8'h96, 8'h87, 1'b1);
      data = 8'h96; amount = 8'h87; op = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         data = 8'h00; amount = 8'h87; op = 1'b1; start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      chk("busy_ignored_result", int'(ref_model(8'h96, 8'h87, 1'b1)), 8'h2D);
      wait_drain(8'h2D);
      repeat (10) @(negedge clk);

      // Reset mid-SHIFT aborts without DONE
      issue(8'hC3, 8'h85, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      sbq.delete();
      @(posedge clk);
      #1;
      chk("abort_result", int'(result), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      run_op(8'hC3, 8'h85, 1'b0);   // -> FE

      // Reset wins over START on the same edge
      @(negedge clk);
      reset = 1'b1; start = 1'b1; data = 8'hAB; amount = 8'h83;
      @(posedge clk);
      #1;
      chk("reset_over_start_busy", int'(busy), 0);
      chk("reset_over_start_result", int'(result), 0);
      reset = 1'b0; start = 1'b0;
      repeat (10) @(negedge clk);

      for (int i = 0; i < 40; i++)
         run_op(8'($urandom), 8'($urandom), 1'($urandom));

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
